// File: rtl/fifo_ddr_burst_sched.sv
// fifo_ddr_burst_sched: drains the frame FIFO read port into fixed-length DDR
// write bursts. One command (addr/len) per burst, followed by BURST_LEN beats on
// a valid/ready data channel. Addresses are frame-relative and wrap at FRAME_BYTES.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a full burst to be buffered in the FIFO
// CMD    | burst command presented, waiting for cmd_ready
// DATA   | reading the FIFO and streaming beats until the last is accepted
module fifo_ddr_burst_sched #(
    parameter int unsigned       DATA_W      = 128,
    parameter int unsigned       LEVEL_W     = 10,
    parameter int unsigned       BURST_LEN   = 16,
    parameter int unsigned       ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(32'h0010_0000)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [LEVEL_W-1:0] fifo_rd_level,
    input  logic               fifo_rd_empty,
    output logic               fifo_rd_en,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [ADDR_W-1:0]  cmd_addr,
    output logic [7:0]         cmd_len,
    output logic               wdata_valid,
    input  logic               wdata_ready,
    output logic [DATA_W-1:0]  wdata,
    output logic               wdata_last,
    output logic               busy
);

    localparam int unsigned       CNT_W       = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [ADDR_W-1:0] FRAME_END   = BASE_ADDR + FRAME_BYTES;
    localparam logic [7:0]        LAST_IDX    = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                level_ok_q;
    logic                inflight_q;
    logic [1:0]          occ_q;
    logic                wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]   buf_q [2];
    logic [CNT_W-1:0]    rd_cnt_q;
    logic [7:0]          wr_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                pend_q;

    logic                push, pop, burst_done, credit_ok;
    logic [ADDR_W-1:0]   addr_inc, addr_next;

    // Read data lands in the buffer the cycle after the FIFO read; a beat
    // leaving this cycle frees a slot so reads can sustain one per cycle.
    assign push       = inflight_q;
    assign pop        = (occ_q != 2'd0) & wdata_ready;
    assign burst_done = pop & (wr_cnt_q == LAST_IDX);
    assign credit_ok  = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    assign addr_inc   = addr_q + BURST_BYTES;
    assign addr_next  = (addr_inc >= FRAME_END) ? BASE_ADDR : addr_inc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (level_ok_q) state_d = S_CMD;
            S_CMD:   if (cmd_ready)  state_d = S_DATA;
            S_DATA:  if (burst_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state and the output buffer.
    always_comb begin
        busy        = (state_q != S_IDLE);
        cmd_valid   = (state_q == S_CMD);
        cmd_len     = (state_q == S_CMD) ? LAST_IDX : 8'd0;
        cmd_addr    = addr_q;
        fifo_rd_en  = (state_q == S_DATA) && (rd_cnt_q < CNT_W'(BURST_LEN))
                      && credit_ok && !fifo_rd_empty;
        wdata_valid = (occ_q != 2'd0);
        wdata       = buf_q[rd_ptr_q];
        wdata_last  = wdata_valid && (wr_cnt_q == LAST_IDX);
    end

    // Registered water-level compare; the burst only starts once it is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_ok_q <= 1'b0;
        else        level_ok_q <= (fifo_rd_level >= LEVEL_W'(BURST_LEN));
    end

    // Read pipeline: in-flight flag, 2-entry buffer and per-burst counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= 8'd0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (push) begin
                buf_q[wr_ptr_q] <= fifo_rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
            if (state_q != S_DATA) rd_cnt_q <= '0;
            else if (fifo_rd_en)   rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            if (pop) wr_cnt_q <= burst_done ? 8'd0 : wr_cnt_q + 8'd1;
        end
    end

    // Burst address: advance with wrap on completion; a frame restart seen
    // while busy is held and replaces the advance at the end of the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= BASE_ADDR;
            pend_q <= 1'b0;
        end else if (burst_done) begin
            addr_q <= (frame_start || pend_q) ? BASE_ADDR : addr_next;
            pend_q <= 1'b0;
        end else if (frame_start) begin
            if (state_q == S_IDLE) addr_q <= BASE_ADDR;
            else                   pend_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_ddr_burst_sched.sv
// Bench for fifo_ddr_burst_sched: FIFO model, scoreboard of expected beats and
// an address-sequence reference, directed scenarios followed by a random phase.
module tb_fifo_ddr_burst_sched;

    localparam int          DW = 128;
    localparam int          LW = 10;
    localparam int          BL = 16;
    localparam int          AW = 28;
    localparam logic [27:0] BASE  = 28'h0;
    localparam logic [27:0] FRAME = 28'h200;
    localparam logic [27:0] BBYTES = 28'(BL * DW / 8);

    logic          clk = 1'b0;
    logic          rst_n, frame_start, fifo_rd_empty, fifo_rd_en;
    logic          cmd_valid, cmd_ready, wdata_valid, wdata_ready, wdata_last, busy;
    logic [LW-1:0] fifo_rd_level;
    logic [DW-1:0] fifo_rd_data, wdata;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;

    fifo_ddr_burst_sched #(
        .DATA_W(DW), .LEVEL_W(LW), .BURST_LEN(BL), .ADDR_W(AW),
        .BASE_ADDR(BASE), .FRAME_BYTES(FRAME)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .fifo_rd_level(fifo_rd_level), .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata(wdata), .wdata_last(wdata_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         exp_q [$];
    logic [DW-1:0] fifo_q[$];
    int            errors = 0;
    int            checks = 0;
    int            push_idx = 0;
    bit            rand_mode = 0;
    logic          s_rd_en, s_beat, s_valid;

    function automatic void chk(input bit ok, input string name,
                                input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    task automatic upd_level();
        fifo_rd_level = LW'(fifo_q.size());
        fifo_rd_empty = (fifo_q.size() == 0);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        beat_t b;
        b.d  = d;
        b.last = ((push_idx % BL) == BL - 1);
        fifo_q.push_back(d);
        exp_q.push_back(b);
        push_idx++;
        upd_level();
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push_word({$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    // One clock: sample at the falling edge, then update FIFO and inputs after the rise.
    task automatic tick();
        @(negedge clk);
        s_rd_en = fifo_rd_en;
        s_beat  = wdata_valid && wdata_ready;
        s_valid = wdata_valid;
        if (s_rd_en) chk(fifo_q.size() != 0, "rd_en_while_empty", 1, 0);
        @(posedge clk);
        #1;
        if (s_rd_en && fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
        frame_start = 1'b0;
        if (rand_mode) begin
            wdata_ready = 1'($urandom_range(0, 1));
            cmd_ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) frame_start = 1'b1;
        end
        upd_level();
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (exp_q.size() == 0 && !busy) done = 1;
            else tick();
        end
        chk(done, "idle_timeout", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({cmd_valid, wdata_valid, wdata_last, busy, fifo_rd_en} == 5'b0,
            {tag, "_ctrl"}, {cmd_valid, wdata_valid, wdata_last, busy, fifo_rd_en}, 0);
        chk(wdata == '0, {tag, "_wdata"}, wdata, 0);
        chk(cmd_len == 8'd0, {tag, "_len"}, cmd_len, 0);
        chk(cmd_addr == BASE, {tag, "_addr"}, cmd_addr, BASE);
    endtask

    // Monitor / scoreboard: reference address sequence and beat order.
    logic [27:0]   m_addr;
    bit            m_pend, m_active, m_data, pw, pc, m_done;
    int            m_reads, m_out;
    logic [DW-1:0] pw_d;
    logic          pw_l;
    logic [27:0]   pc_a;
    logic [7:0]    pc_l;
    beat_t         m_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_addr = BASE; m_pend = 0; m_active = 0; m_data = 0;
            m_reads = 0; m_out = 0; pw = 0; pc = 0;
        end else begin
            if (pw) chk(wdata_valid && wdata == pw_d && wdata_last == pw_l, "wdata_hold", wdata, pw_d);
            if (pc) chk(cmd_valid && cmd_addr == pc_a && cmd_len == pc_l, "cmd_hold", cmd_addr, pc_a);
            if (cmd_valid && cmd_ready) begin
                chk(cmd_addr == m_addr, "cmd_addr", cmd_addr, m_addr);
                chk(cmd_len == 8'(BL - 1), "cmd_len", cmd_len, BL - 1);
                m_data = 1; m_reads = 0;
            end
            if (cmd_valid) m_active = 1;
            if (fifo_rd_en) begin
                chk(m_data, "rd_outside_data", 1, 0);
                m_reads++;
                m_out++;
                chk(m_reads <= BL, "reads_per_burst", m_reads, BL);
            end
            if (!wdata_valid) chk(!wdata_last, "last_without_valid", wdata_last, 0);
            m_done = 0;
            if (wdata_valid && wdata_ready) begin
                chk(exp_q.size() != 0, "unexpected_beat", wdata, 0);
                if (exp_q.size() != 0) begin
                    m_b = exp_q.pop_front();
                    chk(wdata == m_b.d, "wdata", wdata, m_b.d);
                    chk(wdata_last == m_b.last, "wdata_last", wdata_last, m_b.last);
                    m_done = m_b.last;
                end
                m_out--;
            end
            if (m_data) chk(m_out >= 0 && m_out <= 2, "buffer_depth", m_out, 2);
            if (m_done) begin
                m_addr = (frame_start || m_pend) ? BASE
                         : BASE + ((m_addr - BASE + BBYTES) % FRAME);
                m_pend = 0; m_active = 0; m_data = 0;
            end else if (frame_start) begin
                if (m_active) m_pend = 1;
                else          m_addr = BASE;
            end
            pw   = wdata_valid && !wdata_ready;
            pw_d = wdata;
            pw_l = wdata_last;
            pc   = cmd_valid && !cmd_ready;
            pc_a = cmd_addr;
            pc_l = cmd_len;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=1 required=0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int rd_pulses, valid_cycles, first_v, last_v, n, cyc, pushed;
        bit seen;
        rst_n = 1'b0; frame_start = 1'b0; cmd_ready = 1'b0; wdata_ready = 1'b0;
        fifo_rd_data = '0;
        upd_level();
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Level 15 must not start a burst; 16 raises cmd_valid two cycles later.
        for (int i = 0; i < 15; i++) push_word(DW'(i));
        repeat (6) tick();
        chk(cmd_valid == 1'b0, "lvl15_cmd_valid", cmd_valid, 0);
        chk(busy == 1'b0, "lvl15_busy", busy, 0);
        push_word(DW'(15));
        tick();
        chk(cmd_valid == 1'b0, "cmd_valid_early", cmd_valid, 0);
        tick();
        chk(cmd_valid == 1'b1, "cmd_valid_rise", cmd_valid, 1);
        chk(cmd_addr == 28'h0, "first_addr", cmd_addr, 0);
        chk(cmd_len == 8'd15, "first_len", cmd_len, 15);

        // Command held while not accepted; no FIFO reads yet.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk(cmd_valid && cmd_addr == 28'h0 && cmd_len == 8'd15, "cmd_stall", cmd_addr, 0);
            chk(fifo_rd_en == 1'b0, "rd_en_in_cmd", fifo_rd_en, 0);
        end

        // Full-rate burst: 16 reads, 16 back-to-back beats.
        cmd_ready = 1'b1; wdata_ready = 1'b1;
        rd_pulses = 0; valid_cycles = 0; first_v = -1; last_v = -1; cyc = 0;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            cyc++;
            if (s_rd_en) rd_pulses++;
            if (s_valid) begin
                valid_cycles++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (exp_q.size() == 0 && !busy) seen = 1;
        end
        chk(seen, "burst1_timeout", 0, 1);
        chk(rd_pulses == BL, "rd_pulses", rd_pulses, BL);
        chk(valid_cycles == BL, "valid_cycles", valid_cycles, BL);
        chk(last_v - first_v == BL - 1, "back_to_back", last_v - first_v, BL - 1);
        chk(cmd_addr == 28'h100, "next_addr", cmd_addr, 28'h100);

        // Burst at 0x100, then wrap to 0x000 with a frame restart mid-burst.
        push_rand(BL);
        wait_idle(200);
        chk(cmd_addr == 28'h0, "wrap_addr", cmd_addr, 0);
        push_rand(BL);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (s_valid) seen = 1;
        end
        chk(seen, "data_wait_timeout", 0, 1);
        frame_start = 1'b1;
        wait_idle(200);
        chk(cmd_addr == 28'h0, "frame_restart_addr", cmd_addr, 0);
        push_rand(BL);
        wait_idle(200);
        chk(cmd_addr == 28'h100, "after_restart_addr", cmd_addr, 28'h100);

        // Reset in the middle of a burst at 0x100, after beat 7.
        push_rand(BL);
        n = 0;
        for (int i = 0; i < 100 && n < 7; i++) begin
            tick();
            if (s_beat) n++;
        end
        chk(n == 7, "beat7_timeout", n, 7);
        chk(busy && cmd_addr == 28'h100, "pre_reset_state", cmd_addr, 28'h100);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midburst_reset");
        fifo_q.delete();
        exp_q.delete();
        push_idx = 0;
        upd_level();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        push_rand(BL);
        wait_idle(200);

        // Random back-pressure, arrival pattern and frame restarts.
        rand_mode = 1;
        pushed = 0;
        while (pushed < 6 * BL) begin
            n = $urandom_range(1, 6);
            if (pushed + n > 6 * BL) n = 6 * BL - pushed;
            push_rand(n);
            pushed += n;
            repeat ($urandom_range(0, 5)) tick();
        end
        wait_idle(3000);
        rand_mode = 0;
        chk(fifo_q.size() == 0, "fifo_drained", fifo_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
